// File: rtl/fir_tap_arbiter.sv
// fir_tap_arbiter: shares the single-port tap BRAM between config and FIR engine, with starvation bound and write protection.
// Optional FIR_TAP_ARB_STATS_EN adds arb_conflict_cnt (saturating count of contended cycles).
module fir_tap_arbiter #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pMAX_WAIT   = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   ap_running,
  input  logic                   cfg_req,
  input  logic                   cfg_we,
  input  logic [pADDR_WIDTH-1:0] cfg_addr,
  input  logic [pDATA_WIDTH-1:0] cfg_wdata,
  output logic                   cfg_gnt,
  output logic                   cfg_rvalid,
  output logic [pDATA_WIDTH-1:0] cfg_rdata,
  output logic                   cfg_wr_err,
  input  logic                   eng_req,
  input  logic [pADDR_WIDTH-1:0] eng_addr,
  output logic                   eng_gnt,
  output logic                   eng_rvalid,
  output logic [pDATA_WIDTH-1:0] eng_rdata,
`ifdef FIR_TAP_ARB_STATS_EN
  output logic [15:0]            arb_conflict_cnt,
`endif
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);
  localparam int WW = $clog2(pMAX_WAIT + 1);
  logic [WW-1:0] wait_cnt;
  logic          cfg_pend, eng_pend, wr_err;
  logic          starved;
  // Everything is gated by reset so the reset cycle itself shows all-zero outputs.
  always_comb begin
    starved    = wait_cnt == WW'(pMAX_WAIT);
    cfg_gnt    = !axis_rst && cfg_req && (!ap_running || !eng_req || starved);
    eng_gnt    = !axis_rst && eng_req && !cfg_gnt;
    tap_EN     = cfg_gnt || eng_gnt;
    tap_A      = cfg_gnt ? cfg_addr : eng_gnt ? eng_addr : '0;
    tap_Di     = tap_EN ? cfg_wdata : '0;
    tap_WE     = (cfg_gnt && cfg_we && !ap_running) ? 4'hF : 4'h0;
    cfg_rvalid = cfg_pend && !axis_rst;
    eng_rvalid = eng_pend && !axis_rst;
    cfg_rdata  = cfg_rvalid ? tap_Do : '0;
    eng_rdata  = eng_rvalid ? tap_Do : '0;
    cfg_wr_err = wr_err && !axis_rst;
  end
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      wait_cnt <= '0;
      cfg_pend <= 1'b0;
      eng_pend <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      wait_cnt <= (cfg_req && !cfg_gnt) ? (starved ? wait_cnt : wait_cnt + 1'b1) : '0;
      cfg_pend <= cfg_gnt && !cfg_we;
      eng_pend <= eng_gnt;
      wr_err   <= cfg_gnt && cfg_we && ap_running;
    end
  end
`ifdef FIR_TAP_ARB_STATS_EN
  always_ff @(posedge axis_clk) begin
    if (axis_rst) arb_conflict_cnt <= '0;
    else if (cfg_req && eng_req && arb_conflict_cnt != 16'hFFFF) arb_conflict_cnt <= arb_conflict_cnt + 16'd1;
  end
`endif
endmodule

// File: doc/fir_tap_arbiter.md
Name: fir_tap_arbiter

Overview:
Arbitrates the single-port tap-coefficient BRAM (bram32, 1-cycle registered read) between two requesters: the AXI-Lite config path (coefficient program/readback) and the FIR compute engine (tap fetch). It sits between the fir AXI-Lite decoder / MAC sequencer and the tap_RAM port. It enforces write protection while the engine runs and bounds config-read starvation.

Parameters:
pADDR_WIDTH, 12, byte address width of tap BRAM port
pDATA_WIDTH, 32, data width
pMAX_WAIT, 11, max consecutive cycles a pending cfg request may lose to the engine before it is forced through

Ports:
axis_clk  in  1  single clock
axis_rst  in  1  reset; one clock; reset is synchronous and active-high
ap_running  in  1  engine active (ap_start accepted, ap_done not yet set)
cfg_req  in  1  config access request; held until cfg_gnt
cfg_we  in  1  1=write, 0=read; qualified by cfg_req
cfg_addr  in  pADDR_WIDTH  byte address (0x00-based tap offset)
cfg_wdata  in  pDATA_WIDTH  write data
cfg_gnt  out  1  config request accepted this cycle
cfg_rvalid  out  1  config read data valid
cfg_rdata  out  pDATA_WIDTH  config read data
cfg_wr_err  out  1  one-cycle pulse: write rejected (ap_running)
eng_req  in  1  engine tap read request; held until eng_gnt
eng_addr  in  pADDR_WIDTH  byte address
eng_gnt  out  1  engine request accepted this cycle
eng_rvalid  out  1  engine read data valid
eng_rdata  out  pDATA_WIDTH  engine read data
tap_WE  out  4  BRAM byte write enables
tap_EN  out  1  BRAM enable
tap_Di  out  pDATA_WIDTH  BRAM write data
tap_A  out  pADDR_WIDTH  BRAM byte address
tap_Do  in  pDATA_WIDTH  BRAM read data

Behaviour:
- Reset: all registered state cleared; cfg_rvalid, eng_rvalid, cfg_wr_err = 0; wait_cnt = 0; any in-flight read response is dropped (no rvalid after reset).
- Grant is combinational from current req/state; at most one of cfg_gnt/eng_gnt per cycle.
- Priority, ap_running=0: cfg wins; eng granted only when cfg_req=0.
- Priority, ap_running=1: eng wins unless cfg_req=1 and wait_cnt==pMAX_WAIT, then cfg wins.
- wait_cnt: +1 each cycle with cfg_req=1 and cfg_gnt=0 (saturates at pMAX_WAIT); cleared on cfg_gnt or cfg_req=0.
- BRAM drive (granted cycle T): tap_EN=1; tap_A = winner address; tap_Di = cfg_wdata; tap_WE=4'hF only for cfg write with ap_running=0, else 4'h0. No grant: tap_EN=0, tap_WE=0, tap_A=0, tap_Di=0.
- Read latency: a read granted at cycle T raises the owner's rvalid for exactly one cycle at T+1. rdata = tap_Do in that cycle; rdata = 0 otherwise. No backpressure: requesters must sample at T+1.
- Owner tag is registered at T, so back-to-back grants alternating owners route each response correctly.
- Writes: cfg_gnt at T, no rvalid. If ap_running=1 at T, the write is consumed (cfg_gnt=1, tap_EN=1, tap_WE=0) and cfg_wr_err=1 at T+1.
- Reads while ap_running are allowed (subject to arbitration).
- ap_running change mid-stream: priority is evaluated per cycle from current ap_running; a pending read response is unaffected.

Optional Feature:
FIR_TAP_ARB_STATS_EN: adds output arb_conflict_cnt[15:0]. Counts cycles with cfg_req=1 and eng_req=1; saturates at 16'hFFFF; cleared by reset. Without the macro the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- ap_running=0, cfg write 0x80 <- 32'h0000_0005, then read 0x80 -> tap_WE=4'hF at grant; cfg_rvalid next-next cycle with cfg_rdata=5.
- ap_running=0, cfg_req and eng_req together (read 0x84 / 0x88) -> cfg_gnt first cycle, eng_gnt second; each rvalid one cycle after its own grant, with the correct data.
- ap_running=1, eng_req held continuously, cfg read pending -> cfg_gnt exactly on the 12th cycle after cfg_req rose (pMAX_WAIT=11); eng_gnt on all other cycles.
- ap_running=1, cfg write 0x80 <- 32'hDEAD -> cfg_gnt=1, tap_WE=0, cfg_wr_err pulse 1 cycle; a subsequent read still returns the old value.
- Alternating eng/cfg reads back-to-back -> rvalid and rdata are routed to the correct owner with no lost or duplicated responses.
- axis_rst asserted the cycle after a read grant -> no rvalid at T+1; all outputs 0.
